// File: rtl/ama_riscv_fetch.sv
// ama_riscv_fetch: IF stage with PC register, next-PC mux, IMEM drive and IF/ID register.
// Optional performance counters are enabled by defining AMA_RISCV_FETCH_PERF_EN.
`default_nettype none

module ama_riscv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IMEM_AW      = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pc_sel,
    input  logic [1:0]         pc_we,
    input  logic               imem_en,
    input  logic               stall_if,
    input  logic               clear_if,
    input  logic [31:0]        alu_out,
    input  logic [31:0]        bp_target,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_en_o,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        pc_id,
    output logic [31:0]        inst_id,
    output logic               inst_valid_id
`ifdef AMA_RISCV_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam logic [31:0] NOP               = 32'h0000_0013;
    localparam logic [1:0]  PC_SEL_INC4       = 2'd0;
    localparam logic [1:0]  PC_SEL_ALU        = 2'd1;
    localparam logic [1:0]  PC_SEL_BP         = 2'd2;
    localparam logic [1:0]  PC_SEL_START_ADDR = 2'd3;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] hold_inst;
    logic        kill;

    // Bit 1 of pc_we is reserved and the ALU target is forced halfword aligned.
    logic unused_bits;
    assign unused_bits = ^{pc_we[1], alu_out[0]};

    assign imem_addr = pc[IMEM_AW+1:2];

    always_comb begin
        pc_next = pc + 32'd4;
        case (pc_sel)
            PC_SEL_INC4:       pc_next = pc + 32'd4;
            PC_SEL_ALU:        pc_next = {alu_out[31:1], 1'b0};
            PC_SEL_BP:         pc_next = bp_target;
            PC_SEL_START_ADDR: pc_next = RESET_VECTOR;
            default:           pc_next = pc + 32'd4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        imem_en_o  = imem_en & ~stall_if;
        inst_id    = imem_rdata;
        case (state)
            BOOT: begin
                state_next = RUN;
                imem_en_o  = 1'b1;
                inst_id    = NOP;
            end
            RUN: begin
                if (stall_if) state_next = STALL;
                if (kill)     inst_id    = NOP;
            end
            STALL: begin
                if (!stall_if) state_next = RUN;
                inst_id = hold_inst;
            end
            default: begin
                state_next = BOOT;
                inst_id    = NOP;
            end
        endcase
    end

    // inst_valid_id already reflects a pending kill, so it doubles as the held valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_VECTOR;
            pc_id         <= 32'd0;
            inst_valid_id <= 1'b0;
            kill          <= 1'b0;
            hold_inst     <= NOP;
        end else if (state == BOOT) begin
            // The decoder still drives START_ADDR here; skip past the vector already fetched.
            pc            <= RESET_VECTOR + 32'd4;
            pc_id         <= pc;
            inst_valid_id <= 1'b1;
            kill          <= 1'b0;
        end else begin
            kill <= clear_if;
            if (stall_if) begin
                if (clear_if) begin
                    hold_inst     <= NOP;
                    inst_valid_id <= 1'b0;
                end else if (state == RUN) begin
                    hold_inst <= inst_id;
                end
            end else begin
                if (pc_we[0]) pc <= pc_next;
                pc_id         <= pc;
                inst_valid_id <= ~clear_if;
            end
        end
    end

`ifdef AMA_RISCV_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if ((state == BOOT) || (pc_we[0] && !stall_if))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state != BOOT) && stall_if)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ama_riscv_fetch.sv
// Directed bench for ama_riscv_fetch with a synchronous IMEM model and an expectation queue.
`default_nettype none

module tb_ama_riscv_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_sel = 2'd3;
    logic [1:0]  pc_we = 2'd1;
    logic        imem_en = 1'b1;
    logic        stall_if = 1'b0;
    logic        clear_if = 1'b0;
    logic [31:0] alu_out = 32'd0;
    logic [31:0] bp_target = 32'd0;
    logic [13:0] imem_addr;
    logic        imem_en_o;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] pc;
    logic [31:0] pc_id;
    logic [31:0] inst_id;
    logic        inst_valid_id;
`ifdef AMA_RISCV_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] pc_id;
        logic [31:0] inst;
        logic        valid;
    } exp_t;

    exp_t sb[$];

    ama_riscv_fetch #(
        .RESET_VECTOR(32'h0000_0000),
        .IMEM_AW(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc_sel(pc_sel),
        .pc_we(pc_we),
        .imem_en(imem_en),
        .stall_if(stall_if),
        .clear_if(clear_if),
        .alu_out(alu_out),
        .bp_target(bp_target),
        .imem_addr(imem_addr),
        .imem_en_o(imem_en_o),
        .imem_rdata(imem_rdata),
        .pc(pc),
        .pc_id(pc_id),
        .inst_id(inst_id),
        .inst_valid_id(inst_valid_id)
`ifdef AMA_RISCV_FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [13:0] a);
        return 32'hA500_0000 | {18'd0, a};
    endfunction

    always @(posedge clk) begin
        if (imem_en_o) imem_rdata <= memval(imem_addr);
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk32({e.tag, ".pc"}, pc, e.pc);
        chk32({e.tag, ".pc_id"}, pc_id, e.pc_id);
        chk32({e.tag, ".inst_id"}, inst_id, e.inst);
        chk32({e.tag, ".valid"}, {31'd0, inst_valid_id}, {31'd0, e.valid});
    endtask

    // Drive one cycle of controls, queue what ID must show after the edge, then compare.
    task automatic step(input string tag, input logic [1:0] sel, input logic we,
                        input logic stl, input logic clr,
                        input logic [31:0] e_pc, input logic [31:0] e_pcid,
                        input logic [31:0] e_inst, input logic e_valid);
        exp_t e;
        pc_sel   = sel;
        pc_we    = {1'b0, we};
        stall_if = stl;
        clear_if = clr;
        e.tag = tag; e.pc = e_pc; e.pc_id = e_pcid; e.inst = e_inst; e.valid = e_valid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk32("rst.pc", pc, 32'h0);
        chk32("rst.pc_id", pc_id, 32'h0);
        chk32("rst.inst_id", inst_id, NOP);
        chk32("rst.valid", {31'd0, inst_valid_id}, 32'd0);
        chk32("rst.imem_en_o", {31'd0, imem_en_o}, 32'd1);
        rst = 1'b0;

        // Boot edge with START_ADDR still selected, then sequential fetch.
        step("boot",  2'd3, 1'b1, 1'b0, 1'b0, 32'h04, 32'h00, memval(14'h0), 1'b1);
        step("inc1",  2'd0, 1'b1, 1'b0, 1'b0, 32'h08, 32'h04, memval(14'h1), 1'b1);
        step("inc2",  2'd0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'h08, memval(14'h2), 1'b1);
        step("inc3",  2'd0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0C, memval(14'h3), 1'b1);

        // Three-cycle stall at pc=0x10.
        step("stl1",  2'd0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0C, memval(14'h3), 1'b1);
        chk32("stl1.imem_en_o", {31'd0, imem_en_o}, 32'd0);
        step("stl2",  2'd0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0C, memval(14'h3), 1'b1);
        step("stl3",  2'd0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0C, memval(14'h3), 1'b1);
        step("res1",  2'd0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h10, memval(14'h4), 1'b1);
        step("res2",  2'd0, 1'b1, 1'b0, 1'b0, 32'h18, 32'h14, memval(14'h5), 1'b1);
`ifdef AMA_RISCV_FETCH_PERF_EN
        chk32("perf.fetch", perf_fetch_cnt, 32'd6);
        chk32("perf.stall", perf_stall_cnt, 32'd3);
`endif

        // ALU redirect with a kill of the wrong-path instruction.
        alu_out = 32'h0000_0101;
        step("jmp",   2'd1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h18, NOP, 1'b0);
        step("tgt1",  2'd0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h100, memval(14'h40), 1'b1);
        step("tgt2",  2'd0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h104, memval(14'h41), 1'b1);

        // PC write disabled: same instruction re-presented as valid.
        step("hold1", 2'd0, 1'b0, 1'b0, 1'b0, 32'h108, 32'h108, memval(14'h42), 1'b1);
        step("hold2", 2'd0, 1'b0, 1'b0, 1'b0, 32'h108, 32'h108, memval(14'h42), 1'b1);
        step("hold3", 2'd0, 1'b1, 1'b0, 1'b0, 32'h10C, 32'h108, memval(14'h42), 1'b1);

        // clear_if with stall_if: bubble for the whole stall.
        step("cs1",   2'd0, 1'b1, 1'b1, 1'b1, 32'h10C, 32'h108, NOP, 1'b0);
        step("cs2",   2'd0, 1'b1, 1'b1, 1'b1, 32'h10C, 32'h108, NOP, 1'b0);
        step("cs_r1", 2'd0, 1'b1, 1'b0, 1'b0, 32'h110, 32'h10C, memval(14'h43), 1'b1);
        step("cs_r2", 2'd0, 1'b1, 1'b0, 1'b0, 32'h114, 32'h110, memval(14'h44), 1'b1);

        // Predicted target, then ALU target with bit 0 set near the top of memory, then wrap.
        bp_target = 32'h0000_0200;
        step("bp",    2'd2, 1'b1, 1'b0, 1'b0, 32'h200, 32'h114, memval(14'h45), 1'b1);
        alu_out = 32'hFFFF_FFFD;
        step("top",   2'd1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h200, memval(14'h80), 1'b1);
        step("wrap",  2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, memval(14'h3FFF), 1'b1);

        // Reset mid-stall with a kill pending.
        step("pre_rst", 2'd0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC, NOP, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk32("arst.pc", pc, 32'h0);
        chk32("arst.pc_id", pc_id, 32'h0);
        chk32("arst.inst_id", inst_id, NOP);
        chk32("arst.valid", {31'd0, inst_valid_id}, 32'd0);
`ifdef AMA_RISCV_FETCH_PERF_EN
        chk32("arst.perf_fetch", perf_fetch_cnt, 32'd0);
        chk32("arst.perf_stall", perf_stall_cnt, 32'd0);
`endif
        stall_if = 1'b0;
        clear_if = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("reboot", 2'd3, 1'b1, 1'b0, 1'b0, 32'h04, 32'h00, memval(14'h0), 1'b1);
        step("reinc",  2'd0, 1'b1, 1'b0, 1'b0, 32'h08, 32'h04, memval(14'h1), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
